// File: rtl/axi_pack.sv
// Shared stream types and sizing helpers for the AXI-Stream FIFO.
// Imported by the FIFO top, its storage array and the bench.
package axi_pack;

    localparam int AXI_DW = 32;

    typedef struct packed {
        logic [AXI_DW-1:0] data;
        logic              last;
    } axi_beat_t;

    // Pointer width carries one extra wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_if.sv
// AXI-Stream handshake bundle with producer/consumer views.
// The FIFO takes a slave view on input and a master view on output.
interface axis_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] tData;
    logic                  tLast;
    logic                  tValid;
    logic                  tReady;

    modport master (
        output tData,
        output tLast,
        output tValid,
        input  tReady
    );

    modport slave (
        input  tData,
        input  tLast,
        input  tValid,
        output tReady
    );

endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port register array: one write port, async read port.
// Contents are deliberately left unreset.
module axis_fifo_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet mode.
// Ready/valid are derived from registered pointers only.
module axis_fifo
    import axi_pack::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axis_fifo_if.slave                s,
    axis_fifo_if.master               m,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic [ptr_w(DEPTH)-1:0]   pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] pkt_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          pkt_ok;
    beat_t         wbeat;
    beat_t         rbeat;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Full override keeps packets longer than DEPTH from deadlocking.
    assign pkt_ok = (PACKET_MODE == 0) || (pkt_q != '0) || full;

    assign s.tReady = !full;
    assign m.tValid = !empty && pkt_ok;

    assign push = s.tValid && s.tReady;
    assign pop  = m.tValid && m.tReady;

    assign wbeat = '{data: s.tData, last: s.tLast};
    assign m.tData = rbeat.data;
    assign m.tLast = rbeat.last;

    assign count     = wr_ptr - rd_ptr;
    assign pkt_count = pkt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pkt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push && s.tLast, pop && m.tLast})
                2'b10:   pkt_q <= pkt_q + PW'(1);
                2'b01:   pkt_q <= pkt_q - PW'(1);
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    axis_fifo_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wbeat),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rbeat)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: stream mode and packet mode side by side,
// both driven with the same stimulus and a queue-based model each.
module tb_axis_fifo;
    import axi_pack::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_fifo_if #(.DATA_WIDTH(DW)) s0 ();
    axis_fifo_if #(.DATA_WIDTH(DW)) m0 ();
    axis_fifo_if #(.DATA_WIDTH(DW)) s1 ();
    axis_fifo_if #(.DATA_WIDTH(DW)) m1 ();

    logic [PW-1:0] count0, pkt0, count1, pkt1;

    axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut0 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s         (s0),
        .m         (m0),
        .count     (count0),
        .pkt_count (pkt0)
    );

    axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut1 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s         (s1),
        .m         (m1),
        .count     (count1),
        .pkt_count (pkt1)
    );

    int errors = 0;
    int checks = 0;

    axi_beat_t q0[$];
    axi_beat_t q1[$];

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        r;
        int          c0;
        logic        mv0;
        int          c1;
        logic        mv1;
        int          p1;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int lasts(input axi_beat_t q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i].last);
        return n;
    endfunction

    function automatic bit exp_mv(input axi_beat_t q[$], input bit pm);
        return q.size() != 0 &&
               (!pm || lasts(q) != 0 || q.size() == DEPTH);
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic l, input logic r);
        s0.tValid = v; s0.tData = d; s0.tLast = l; m0.tReady = r;
        s1.tValid = v; s1.tData = d; s1.tLast = l; m1.tReady = r;
    endtask

    task automatic check_state();
        bit mv0, mv1;
        mv0 = exp_mv(q0, 1'b0);
        mv1 = exp_mv(q1, 1'b1);
        chk("count0", 64'(count0), 64'(q0.size()));
        chk("pkt0", 64'(pkt0), 64'(lasts(q0)));
        chk("ready0", 64'(s0.tReady), 64'(q0.size() != DEPTH));
        chk("valid0", 64'(m0.tValid), 64'(mv0));
        if (mv0) begin
            chk("data0", 64'(m0.tData), 64'(q0[0].data));
            chk("last0", 64'(m0.tLast), 64'(q0[0].last));
        end
        chk("count1", 64'(count1), 64'(q1.size()));
        chk("pkt1", 64'(pkt1), 64'(lasts(q1)));
        chk("ready1", 64'(s1.tReady), 64'(q1.size() != DEPTH));
        chk("valid1", 64'(m1.tValid), 64'(mv1));
        if (mv1) begin
            chk("data1", 64'(m1.tData), 64'(q1[0].data));
            chk("last1", 64'(m1.tLast), 64'(q1[0].last));
        end
    endtask

    // Drive one cycle, advance the models by the handshake rules,
    // then compare every output one time unit after the edge.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r);
        bit a0, a1, c0, c1;
        drive(v, d, l, r);
        a0 = v && q0.size() < DEPTH;
        a1 = v && q1.size() < DEPTH;
        c0 = exp_mv(q0, 1'b0) && r;
        c1 = exp_mv(q1, 1'b1) && r;
        @(posedge aclk);
        if (c0) void'(q0.pop_front());
        if (a0) q0.push_back('{data: d, last: l});
        if (c1) void'(q1.pop_front());
        if (a1) q1.push_back('{data: d, last: l});
        #1;
        check_state();
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        aresetn = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 1, 1'b1, 1, 1'b0, 0};
        tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 2, 1'b1, 2, 1'b0, 0};
        tbl[2] = '{1'b1, 32'hC, 1'b1, 1'b0, 3, 1'b1, 3, 1'b1, 1};
        tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 2, 1'b1, 2, 1'b1, 1};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b1, 1, 1'b1, 1};
        tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0};
        tbl[6] = '{1'b1, 32'hD, 1'b1, 1'b1, 1, 1'b1, 1, 1'b1, 1};
        tbl[7] = '{1'b1, 32'hE, 1'b0, 1'b1, 1, 1'b1, 1, 1'b0, 0};
        tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0, 0};

        do_reset();
        chk("rst_count0", 64'(count0), 64'd0);
        chk("rst_ready0", 64'(s0.tReady), 64'd1);
        chk("rst_valid0", 64'(m0.tValid), 64'd0);
        chk("rst_pkt1", 64'(pkt1), 64'd0);
        check_state();

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk("tbl_count0", 64'(count0), 64'(tbl[i].c0));
            chk("tbl_valid0", 64'(m0.tValid), 64'(tbl[i].mv0));
            chk("tbl_count1", 64'(count1), 64'(tbl[i].c1));
            chk("tbl_valid1", 64'(m1.tValid), 64'(tbl[i].mv1));
            chk("tbl_pkt1", 64'(pkt1), 64'(tbl[i].p1));
        end

        // Fill to full with the consumer stalled, then overflow once.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
        end
        chk("fill_count", 64'(count0), 64'(DEPTH));
        chk("fill_ready", 64'(s0.tReady), 64'd0);
        chk("pkt_ovf_valid", 64'(m1.tValid), 64'd1);
        step(1'b1, DW'(99), 1'b0, 1'b0);
        chk("ovf_count", 64'(count0), 64'(DEPTH));
        chk("ovf_head", 64'(m0.tData), 64'd0);

        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", 64'(m0.tValid), 64'd1);
            chk("drain_data", 64'(m0.tData), 64'(i));
            step(1'b0, '0, 1'b0, 1'b1);
        end
        chk("drain_count", 64'(count0), 64'd0);
        chk("drain_valid_end", 64'(m0.tValid), 64'd0);

        // Streaming with both sides always active.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                chk("conc_valid", 64'(m0.tValid), 64'd1);
                chk("conc_data", 64'(m0.tData), 64'(1000 + i - 1));
            end
            step(1'b1, DW'(1000 + i), 1'b0, 1'b1);
            chk("conc_count", 64'(count0), 64'd1);
        end

        // Asynchronous reset away from any clock edge.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'(50 + i), (i == 1 || i == 4), 1'b0);
        end
        chk("pre_rst_count1", 64'(count1), 64'd5);
        chk("pre_rst_pkt1", 64'(pkt1), 64'd2);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_count1", 64'(count1), 64'd0);
        chk("arst_pkt1", 64'(pkt1), 64'd0);
        chk("arst_valid1", 64'(m1.tValid), 64'd0);
        chk("arst_count0", 64'(count0), 64'd0);
        chk("arst_valid0", 64'(m0.tValid), 64'd0);
        do_reset();
        check_state();

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(3) != 0, DW'($urandom),
                 $urandom_range(3) == 0, $urandom_range(3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
